// File: rtl/run_detect_fsm.sv
// rtl/run_detect_fsm.sv - run-length detector for consecutive ones on a serial bit stream
//
// Optional feature macro: DET_COUNT_EN (adds clr_cnt input and det_cnt output).
//
// Ports:
//   clk      in   single clock, all state updates on its rising edge
//   reset    in   synchronous active-low reset
//   data_in  in   serial bit, sampled when en is high
//   en       in   sample enable; data_in ignored while low
//   thr      in   [CW] run-length threshold, 0 disables detection
//   mode     in   0 = overlapping detection, 1 = non-overlapping detection
//   detect   out  registered detection flag
//   run_len  out  [CW] registered count of consecutive sampled ones
//   clr_cnt  in   synchronous clear of det_cnt (DET_COUNT_EN only)
//   det_cnt  out  [DW] saturating detection count (DET_COUNT_EN only)
module run_detect_fsm #(
    parameter int CW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_in,
    input  logic          en,
    input  logic [CW-1:0] thr,
    input  logic          mode,
    output logic          detect,
    output logic [CW-1:0] run_len
`ifdef DET_COUNT_EN
    ,
    input  logic          clr_cnt,
    output logic [DW-1:0] det_cnt
`endif
);

    if (CW < 1 || DW < 1) begin : g_bad_param
        $error("run_detect_fsm: CW and DW must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HIT  = 2'b10
    } state_t;

    state_t        state;
    logic [CW-1:0] run_inc;
    logic          state_legal;
    logic          hit;
    logic          det_set;

    always_comb begin
        // Run length saturates rather than wrapping so a long run never looks short.
        run_inc     = (run_len == {CW{1'b1}}) ? run_len : run_len + 1'b1;
        state_legal = (state == S_IDLE) || (state == S_RUN) || (state == S_HIT);
        hit         = (thr != '0) && (run_inc >= thr);
        // Edge on which detect will be loaded with 1; shared with the counter.
        det_set     = reset && state_legal && en && data_in && hit;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            run_len <= '0;
            detect  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RUN, S_HIT: begin
                    if (!en) begin
                        detect <= 1'b0;
                    end else if (!data_in) begin
                        state   <= S_IDLE;
                        run_len <= '0;
                        detect  <= 1'b0;
                    end else if (hit) begin
                        detect <= 1'b1;
                        if (mode) begin
                            // Non-overlapping: consume the run so the next hit needs thr fresh ones.
                            state   <= S_IDLE;
                            run_len <= '0;
                        end else begin
                            state   <= S_HIT;
                            run_len <= run_inc;
                        end
                    end else begin
                        state   <= S_RUN;
                        run_len <= run_inc;
                        detect  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    run_len <= '0;
                    detect  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DET_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            det_cnt <= '0;
        end else if (clr_cnt) begin
            // Clear wins over a detection on the same edge.
            det_cnt <= '0;
        end else if (det_set && (det_cnt != {DW{1'b1}})) begin
            det_cnt <= det_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_run_detect_fsm.sv
// tb/tb_run_detect_fsm.sv - directed self-checking bench for run_detect_fsm
module tb_run_detect_fsm;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic       en;
    logic [3:0] thr;
    logic       mode;
    logic       detect;
    logic [3:0] run_len;
`ifdef DET_COUNT_EN
    logic       clr_cnt;
    logic [1:0] det_cnt;
`endif

    int errors = 0;
    int checks = 0;

    run_detect_fsm #(.CW(4), .DW(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .en      (en),
        .thr     (thr),
        .mode    (mode),
        .detect  (detect),
        .run_len (run_len)
`ifdef DET_COUNT_EN
        ,
        .clr_cnt (clr_cnt),
        .det_cnt (det_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one sample and return just after the edge that consumed it.
    task automatic step(input logic d, input logic e);
        data_in = d;
        en      = e;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic d, input logic e,
                            input int exp_rl, input int exp_det);
        step(d, e);
        chk({tag, "_run_len"}, int'(run_len), exp_rl);
        chk({tag, "_detect"}, int'(detect), exp_det);
    endtask

    initial begin
        reset   = 1'b0;
        data_in = 1'b1;
        en      = 1'b1;
        thr     = 4'd3;
        mode    = 1'b0;
`ifdef DET_COUNT_EN
        clr_cnt = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_run_len", int'(run_len), 0);
        chk("reset_detect", int'(detect), 0);
`ifdef DET_COUNT_EN
        chk("reset_det_cnt", int'(det_cnt), 0);
`endif
        reset = 1'b1;

        // Scenario 1: overlapping, thr=3
        thr = 4'd3; mode = 1'b0;
        step_chk("s1_0", 1'b0, 1'b1, 0, 0);
        step_chk("s1_1", 1'b1, 1'b1, 1, 0);
        step_chk("s1_2", 1'b1, 1'b1, 2, 0);
        step_chk("s1_3", 1'b1, 1'b1, 3, 1);
        step_chk("s1_4", 1'b1, 1'b1, 4, 1);
        step_chk("s1_5", 1'b0, 1'b1, 0, 0);

        // Scenario 2: non-overlapping, thr=3, seven ones
        mode = 1'b1;
        step_chk("s2_1", 1'b1, 1'b1, 1, 0);
        step_chk("s2_2", 1'b1, 1'b1, 2, 0);
        step_chk("s2_3", 1'b1, 1'b1, 0, 1);
        step_chk("s2_4", 1'b1, 1'b1, 1, 0);
        step_chk("s2_5", 1'b1, 1'b1, 2, 0);
        step_chk("s2_6", 1'b1, 1'b1, 0, 1);
        step_chk("s2_7", 1'b1, 1'b1, 1, 0);

        // Scenario 3: enable gaps, thr=2
        mode = 1'b0; thr = 4'd2;
        step_chk("s3_clr", 1'b0, 1'b1, 0, 0);
        step_chk("s3_a",   1'b1, 1'b1, 1, 0);
        step_chk("s3_gap1", 1'b1, 1'b0, 1, 0);
        step_chk("s3_gap2", 1'b0, 1'b0, 1, 0);
        step_chk("s3_b",   1'b1, 1'b1, 2, 1);
        step_chk("s3_gap3", 1'b1, 1'b0, 2, 0);

        // Scenario 4: thr=0 disables detection, run_len saturates
        thr = 4'd0;
        step_chk("s4_clr", 1'b0, 1'b1, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step_chk($sformatf("s4_%0d", i), 1'b1, 1'b1, (i > 15) ? 15 : i, 0);
        end

        // Scenario 5: reset mid-run discards the partial run
        thr = 4'd3;
        step_chk("s5_clr", 1'b0, 1'b1, 0, 0);
        step_chk("s5_a", 1'b1, 1'b1, 1, 0);
        step_chk("s5_b", 1'b1, 1'b1, 2, 0);
        reset = 1'b0;
        step_chk("s5_rst", 1'b1, 1'b1, 0, 0);
        reset = 1'b1;
        step_chk("s5_c", 1'b1, 1'b1, 1, 0);
        step_chk("s5_d", 1'b1, 1'b1, 2, 0);

        // Mode switch 0->1 while in S_HIT
        thr = 4'd2; mode = 1'b0;
        step_chk("mh_clr", 1'b0, 1'b1, 0, 0);
        step_chk("mh_1", 1'b1, 1'b1, 1, 0);
        step_chk("mh_2", 1'b1, 1'b1, 2, 1);
        step_chk("mh_3", 1'b1, 1'b1, 3, 1);
        mode = 1'b1;
        step_chk("mh_4", 1'b1, 1'b1, 0, 1);
        step_chk("mh_5", 1'b1, 1'b1, 1, 0);

        // Threshold lowered mid-run compares against current run_len
        thr = 4'd5; mode = 1'b0;
        step_chk("tc_clr", 1'b0, 1'b1, 0, 0);
        step_chk("tc_1", 1'b1, 1'b1, 1, 0);
        step_chk("tc_2", 1'b1, 1'b1, 2, 0);
        step_chk("tc_3", 1'b1, 1'b1, 3, 0);
        thr = 4'd2;
        step_chk("tc_4", 1'b1, 1'b1, 4, 1);

`ifdef DET_COUNT_EN
        // Scenario 6: saturating detection counter, DW=2
        reset = 1'b0;
        step(1'b0, 1'b1);
        reset = 1'b1;
        chk("s6_rst_det_cnt", int'(det_cnt), 0);
        thr = 4'd1; mode = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("s6_cnt_%0d", i), int'(det_cnt), (i > 3) ? 3 : i);
            chk($sformatf("s6_det_%0d", i), int'(detect), 1);
        end
        clr_cnt = 1'b1;
        step(1'b1, 1'b1);
        chk("s6_clr_det_cnt", int'(det_cnt), 0);
        chk("s6_clr_detect", int'(detect), 1);
        clr_cnt = 1'b0;
        step(1'b1, 1'b1);
        chk("s6_after_clr", int'(det_cnt), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
